mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS core.
- Consumes the register file's two read ports (rs, rt operand values) in the execute stage.
- Executes mult/multu/div/divu with a fixed latency; mthi/mtlo writes take one cycle.
- Drives HI/LO for mfhi/mflo and a busy flag that the hazard unit uses to stall.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_hilo_if.sv | 23 ++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu_hilo.sv | 122 ++++++++++++
 tb/tb_mdu_hilo.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states and widths.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
  import mdu_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [31:0]     rs_data;
  logic [31:0]     rt_data;
  logic [31:0]     pc;
  logic            busy;
  logic [31:0]     hi;
  logic [31:0]     lo;

  modport master (
    output start, op, rs_data, rt_data, pc,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, pc,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu; wr is low for
// divide-by-zero and non-arithmetic ops so HI/LO are left untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic [63:0]     result,
  output logic            wr
);

  logic signed [63:0] a_s, b_s, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_nz, a_mag, b_mag, b_mag_nz;
  logic [31:0]        uq, ur, mq, mr, sq, sr;

  always_comb begin
    a_s    = {{32{a[31]}}, a};
    b_s    = {{32{b[31]}}, b};
    prod_s = a_s * b_s;
    prod_u = {32'd0, a} * {32'd0, b};

    // Guard the divisor so the datapath never divides by zero; wr masks the result.
    b_nz     = (b == 32'd0) ? 32'd1 : b;
    a_mag    = a[31] ? (32'd0 - a) : a;
    b_mag    = b[31] ? (32'd0 - b) : b;
    b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;

    uq = a / b_nz;
    ur = a % b_nz;

    // Magnitude division makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
    mq = a_mag / b_mag_nz;
    mr = a_mag % b_mag_nz;
    sq = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
    sr = a[31] ? (32'd0 - mr) : mr;

    result = '0;
    wr     = 1'b0;
    case (op)
      MDU_MULT:  begin result = prod_s;   wr = 1'b1;         end
      MDU_MULTU: begin result = prod_u;   wr = 1'b1;         end
      MDU_DIV:   begin result = {sr, sq}; wr = (b != 32'd0); end
      MDU_DIVU:  begin result = {ur, uq}; wr = (b != 32'd0); end
      default:   begin result = '0;       wr = 1'b0;         end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and busy stall flag.
// Optional MDU_TRACE_EN prints HI/LO write trace lines using the issuing pc.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_hilo_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept, mthi_acc, mtlo_acc, commit;
  logic [63:0]       res;
  logic              res_wr;
  logic [63:0]       pending;
  logic              pending_wr;
  logic [31:0]       hi_q, lo_q;

  mdu_arith u_arith (
    .op     (bus.op),
    .a      (bus.rs_data),
    .b      (bus.rt_data),
    .result (res),
    .wr     (res_wr)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    mthi_acc  = 1'b0;
    mtlo_acc  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU: begin
              accept    = 1'b1;
              cnt_nxt   = CNT_W'(MULT_CYCLES);
              state_nxt = ST_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              accept    = 1'b1;
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              state_nxt = ST_BUSY;
            end
            MDU_MTHI: mthi_acc = 1'b1;
            MDU_MTLO: mtlo_acc = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_BUSY: begin
        // Any start seen here is dropped; the hazard unit never issues while busy.
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mthi_acc) hi_q <= bus.rs_data;
      if (mtlo_acc) lo_q <= bus.rs_data;
      if (commit && pending_wr) begin
        hi_q <= pending[63:32];
        lo_q <= pending[31:0];
      end
    end
  end

  // Result is computed at accept so operand changes during BUSY have no effect.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending    <= res;
      pending_wr <= res_wr;
    end
  end

  assign bus.busy = (state == ST_BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

`ifdef MDU_TRACE_EN
  logic [31:0] pc_lat;

  always_ff @(posedge clk) begin
    if (accept) pc_lat <= bus.pc;
    if (!reset) begin
      if (mthi_acc) $display("@%h: HI <= %h", bus.pc, bus.rs_data);
      if (mtlo_acc) $display("@%h: LO <= %h", bus.pc, bus.rs_data);
      if (commit && pending_wr) begin
        $display("@%h: HI <= %h", pc_lat, pending[63:32]);
        $display("@%h: LO <= %h", pc_lat, pending[31:0]);
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic results, busy timing, mthi/mtlo, reset abort.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for a single cycle, scramble operands, then count busy-high cycles.
  task automatic run_op(input logic [OP_W-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int busy_cycles);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.pc      = 32'h0040_0100;
    tick();
    bus.start   = 1'b0;
    bus.rs_data = 32'h5A5A_A5A5;
    bus.rt_data = 32'h0000_0001;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", bus.lo); end
  endtask

  task automatic test_mult();
    int n;
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); end
  endtask

  task automatic test_multu();
    int n;
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (bus.hi !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
  endtask

  task automatic test_divu_zero();
    int n;
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_data = 32'h11;
    tick();
    bus.op = MDU_MTLO; bus.rs_data = 32'h22;
    tick();
    bus.start = 1'b0;
    run_op(MDU_DIVU, 32'd7, 32'd0, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL divz_busy got=%0d exp=10", n); end
    checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL divz_hi got=%h exp=00000011", bus.hi); end
    checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL divz_lo got=%h exp=00000022", bus.lo); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_hi got=%h exp=deadbeef", bus.hi); end
    checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL mthi_lo got=%h exp=00000022", bus.lo); end
    bus.op = MDU_MTLO; bus.rs_data = 32'h1234_5678;
    tick();
    checks++; if (bus.lo !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_lo got=%h exp=12345678", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%0b exp=0", bus.busy); end
    bus.op = 3'd6; bus.rs_data = 32'hFFFF_0000;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h1234_5678) begin
      failures++; $display("FAIL reserved_op got=%0b/%h/%h exp=0/deadbeef/12345678", bus.busy, bus.hi, bus.lo);
    end
    // MULT 2x3 in flight; an MTLO during busy must be dropped.
    bus.start = 1'b1; bus.op = MDU_MULT; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    tick();
    bus.op = MDU_MTLO; bus.rs_data = 32'h0000_0BAD;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.lo !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_busy_drop got=%h exp=12345678", bus.lo); end
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (bus.lo !== 32'h6 || bus.hi !== 32'h0) begin
      failures++; $display("FAIL mult_after_drop got=%h_%h exp=00000000_00000006", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_abort();
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_data = 32'h0000_0077;
    tick();
    bus.op = MDU_MULT; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++; $display("FAIL abort_hilo got=%h_%h exp=00000000_00000000", bus.hi, bus.lo);
    end
    repeat (8) tick();
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_commit got=%0b/%h_%h exp=0/00000000_00000000", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL ovf_busy got=%0d exp=10", n); end
    checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL ovf_lo got=%h exp=80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL ovf_hi got=%h exp=00000000", bus.hi); end
    run_op(MDU_MULT, 32'd3, 32'd4, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL b2b_busy got=%0d exp=5", n); end
    checks++; if (bus.lo !== 32'h0000_000C) begin failures++; $display("FAIL b2b_lo got=%h exp=0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL b2b_hi got=%h exp=00000000", bus.hi); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = MDU_MULT;
    bus.rs_data = 32'h0;
    bus.rt_data = 32'h0;
    bus.pc      = 32'h0040_0000;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_mthi_mtlo();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
